// File: rtl/ex_wb_pipe_pkg.sv
// ex_wb_pipe_pkg: shared state encoding and payload width helper for the EX->WB pipe
package ex_wb_pipe_pkg;
  typedef enum logic [1:0] {
    EX_WB_EMPTY = 2'd0,
    EX_WB_ONE   = 2'd1,
    EX_WB_TWO   = 2'd2
  } state_t;
  function automatic int payload_w(input int dw, input int aw, input int lw, input int mw);
    return 2 * dw + aw + lw + mw + 1;
  endfunction
endpackage

// File: rtl/ex_wb_slot.sv
// ex_wb_slot: load-enabled payload register with asynchronous clear
module ex_wb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/ex_wb_pipe.sv
// ex_wb_pipe: elastic EX->WB pipeline register with flush and optional two-entry skid
module ex_wb_pipe
  import ex_wb_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int LOAD_W  = 3,
  parameter int MUX_W   = 2,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] pc_plus_i,
  input  logic [LOAD_W-1:0] control_load_i,
  input  logic [MUX_W-1:0]  control_wr_mux_i,
  input  logic              control_wb_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] pc_plus_o,
  output logic [LOAD_W-1:0] control_load_o,
  output logic [MUX_W-1:0]  control_wr_mux_o,
  output logic [1:0]        addr_offset,
  output logic              wb_en_o
);
  localparam int PW = payload_w(DATA_W, REG_AW, LOAD_W, MUX_W);
  state_t state, state_n;
  logic rdy_q, push, pop, main_en, wb_o;
  logic [PW-1:0] in_p, main_d, main_q;
  assign in_p = {pc_plus_i, alu_result_i, wb_addr_i, control_load_i, control_wr_mux_i, control_wb_i};
  assign out_valid = state != EX_WB_EMPTY;
  assign in_ready = (SKID_EN != 0) ? rdy_q : (~out_valid | out_ready);
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_n = flush ? EX_WB_EMPTY :
              state == EX_WB_EMPTY ? (push ? EX_WB_ONE : EX_WB_EMPTY) :
              state == EX_WB_ONE ? (push & ~pop ? EX_WB_TWO : ~push & pop ? EX_WB_EMPTY : EX_WB_ONE) :
              (pop ? EX_WB_ONE : EX_WB_TWO);
    main_en = ~flush & ((state == EX_WB_EMPTY & push) | (state == EX_WB_ONE & push & pop) |
                        (state == EX_WB_TWO & pop));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EX_WB_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_n;
      rdy_q <= state_n != EX_WB_TWO;
    end
  generate
    if (SKID_EN != 0) begin : g_skid
      logic [PW-1:0] skid_q;
      ex_wb_slot #(.W(PW)) u_skid (
        .clk(clk), .rst(rst), .en(~flush & (state == EX_WB_ONE) & push & ~pop), .d(in_p), .q(skid_q)
      );
      assign main_d = (state == EX_WB_TWO) ? skid_q : in_p;
    end else begin : g_single
      assign main_d = in_p;
    end
  endgenerate
  ex_wb_slot #(.W(PW)) u_main (.clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(main_q));
  assign {pc_plus_o, alu_result_o, wb_addr_o, control_load_o, control_wr_mux_o, wb_o} = main_q;
  assign addr_offset = alu_result_o[1:0];
  assign wb_en_o = out_valid & wb_o & (|wb_addr_o);
endmodule

// File: tb/tb_ex_wb_pipe.sv
// tb_ex_wb_pipe: directed self-checking bench for skid (inst 1) and single-slot (inst 0) variants
module tb_ex_wb_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid[2], out_ready[2], flush[2], in_ready[2], out_valid[2], wb_en[2];
  logic [31:0] alu_i, pc_i;
  logic [4:0] wa_i;
  logic [2:0] ld_i;
  logic [1:0] mux_i;
  logic wb_i;
  logic [31:0] alu_o[2], pc_o[2];
  logic [4:0] wa_o[2];
  logic [2:0] ld_o[2];
  logic [1:0] mux_o[2], off_o[2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ex_wb_pipe #(.SKID_EN(g)) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .alu_result_i(alu_i), .wb_addr_i(wa_i), .pc_plus_i(pc_i), .control_load_i(ld_i),
      .control_wr_mux_i(mux_i), .control_wb_i(wb_i), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .alu_result_o(alu_o[g]), .wb_addr_o(wa_o[g]), .pc_plus_o(pc_o[g]), .control_load_o(ld_o[g]),
      .control_wr_mux_o(mux_o[g]), .addr_offset(off_o[g]), .wb_en_o(wb_en[g])
    );
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int k, input logic v, input logic [31:0] a, input logic [4:0] wa, input logic wb);
    in_valid[k] = v;
    alu_i = a;
    pc_i = a + 32'd4;
    wa_i = wa;
    wb_i = wb;
  endtask
  task automatic clear(input int k);
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    flush[k] = 1'b1;
    step();
    flush[k] = 1'b0;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL rst_valid k=%0d got=%b exp=0", k, out_valid[k]); end
      checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL rst_ready k=%0d got=%b exp=1", k, in_ready[k]); end
      out_ready[k] = 1'b0;
      in_valid[k] = 1'b1;
    end
    alu_i = 32'h55; pc_i = 32'h59; wa_i = 5'd3; wb_i = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid[k] !== 1'b1 || alu_o[k] !== 32'h55) begin failures++; $display("FAIL rst_pre k=%0d got=%b/%h exp=1/00000055", k, out_valid[k], alu_o[k]); end
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL rst_async_valid k=%0d got=%b exp=0", k, out_valid[k]); end
      checks++; if (wb_en[k] !== 1'b0) begin failures++; $display("FAIL rst_async_wben k=%0d got=%b exp=0", k, wb_en[k]); end
      checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL rst_async_ready k=%0d got=%b exp=1", k, in_ready[k]); end
      checks++; if (alu_o[k] !== 32'h0) begin failures++; $display("FAIL rst_async_alu k=%0d got=%h exp=0", k, alu_o[k]); end
      in_valid[k] = 1'b0;
    end
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_stream(input int k);
    logic [31:0] v[3];
    v[0] = 32'h10; v[1] = 32'h14; v[2] = 32'h18;
    clear(k);
    out_ready[k] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(k, 1'b1, v[i], 5'd1, 1'b1);
      checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d i=%0d got=%b exp=1", k, i, in_ready[k]); end
      step();
      checks++; if (out_valid[k] !== 1'b1 || alu_o[k] !== v[i]) begin failures++; $display("FAIL stream_out k=%0d i=%0d got=%b/%h exp=1/%h", k, i, out_valid[k], alu_o[k], v[i]); end
    end
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    step();
    checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL stream_drain k=%0d got=%b exp=0", k, out_valid[k]); end
  endtask
  task automatic test_stall(input int k);
    clear(k);
    out_ready[k] = 1'b0;
    put(k, 1'b1, 32'h20, 5'd2, 1'b1);
    step();
    checks++; if (out_valid[k] !== 1'b1 || alu_o[k] !== 32'h20) begin failures++; $display("FAIL stall_a k=%0d got=%b/%h exp=1/00000020", k, out_valid[k], alu_o[k]); end
    checks++; if (in_ready[k] !== (k == 1)) begin failures++; $display("FAIL stall_ready1 k=%0d got=%b exp=%b", k, in_ready[k], k == 1); end
    put(k, 1'b1, 32'h24, 5'd2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (alu_o[k] !== 32'h20 || out_valid[k] !== 1'b1) begin failures++; $display("FAIL stall_hold k=%0d i=%0d got=%b/%h exp=1/00000020", k, i, out_valid[k], alu_o[k]); end
      checks++; if (in_ready[k] !== 1'b0) begin failures++; $display("FAIL stall_ready2 k=%0d i=%0d got=%b exp=0", k, i, in_ready[k]); end
    end
    out_ready[k] = 1'b1;
    step();
    checks++; if (out_valid[k] !== 1'b1 || alu_o[k] !== 32'h24) begin failures++; $display("FAIL stall_b k=%0d got=%b/%h exp=1/00000024", k, out_valid[k], alu_o[k]); end
    checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL stall_ready3 k=%0d got=%b exp=1", k, in_ready[k]); end
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    step();
    checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL stall_nodup k=%0d got=%b exp=0", k, out_valid[k]); end
  endtask
  task automatic test_flush(input int k);
    clear(k);
    out_ready[k] = 1'b0;
    put(k, 1'b1, 32'h30, 5'd4, 1'b1);
    step();
    put(k, 1'b1, 32'h34, 5'd4, 1'b1);
    step();
    put(k, 1'b1, 32'h38, 5'd4, 1'b1);
    flush[k] = 1'b1;
    step();
    flush[k] = 1'b0;
    checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL flush_valid k=%0d got=%b exp=0", k, out_valid[k]); end
    checks++; if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL flush_ready k=%0d got=%b exp=1", k, in_ready[k]); end
    checks++; if (wb_en[k] !== 1'b0) begin failures++; $display("FAIL flush_wben k=%0d got=%b exp=0", k, wb_en[k]); end
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    out_ready[k] = 1'b1;
    step();
    checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL flush_absent k=%0d got=%b exp=0", k, out_valid[k]); end
  endtask
  task automatic test_wb(input int k);
    clear(k);
    out_ready[k] = 1'b0;
    put(k, 1'b1, 32'h40, 5'd0, 1'b1);
    step();
    checks++; if (out_valid[k] !== 1'b1 || wb_en[k] !== 1'b0) begin failures++; $display("FAIL wb_x0 k=%0d got=%b/%b exp=1/0", k, out_valid[k], wb_en[k]); end
    out_ready[k] = 1'b1;
    put(k, 1'b1, 32'h44, 5'd5, 1'b1);
    step();
    checks++; if (wa_o[k] !== 5'd5 || wb_en[k] !== 1'b1) begin failures++; $display("FAIL wb_x5 k=%0d got=%0d/%b exp=5/1", k, wa_o[k], wb_en[k]); end
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    out_ready[k] = 1'b0;
    flush[k] = 1'b1;
    step();
    flush[k] = 1'b0;
    checks++; if (out_valid[k] !== 1'b0 || wb_en[k] !== 1'b0) begin failures++; $display("FAIL wb_bubble k=%0d got=%b/%b exp=0/0", k, out_valid[k], wb_en[k]); end
  endtask
  task automatic test_offset(input int k);
    clear(k);
    out_ready[k] = 1'b1;
    put(k, 1'b1, 32'h0000_1003, 5'd7, 1'b1);
    ld_i = 3'd5;
    mux_i = 2'd2;
    step();
    checks++; if (alu_o[k] !== 32'h0000_1003 || off_o[k] !== 2'b11) begin failures++; $display("FAIL offset k=%0d got=%h/%b exp=00001003/11", k, alu_o[k], off_o[k]); end
    checks++; if (pc_o[k] !== 32'h0000_1007 || ld_o[k] !== 3'd5 || mux_o[k] !== 2'd2) begin failures++; $display("FAIL fields k=%0d got=%h/%0d/%0d exp=00001007/5/2", k, pc_o[k], ld_o[k], mux_o[k]); end
    put(k, 1'b1, 32'h0000_2002, 5'd7, 1'b0);
    step();
    checks++; if (off_o[k] !== 2'b10 || wb_en[k] !== 1'b0) begin failures++; $display("FAIL offset2 k=%0d got=%b/%b exp=10/0", k, off_o[k], wb_en[k]); end
    put(k, 1'b0, 32'h0, 5'd0, 1'b0);
    ld_i = 3'd0;
    mux_i = 2'd0;
    step();
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      flush[k] = 1'b0;
    end
    alu_i = '0; pc_i = '0; wa_i = '0; ld_i = '0; mux_i = '0; wb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    test_reset();
    for (int k = 0; k < 2; k++) begin
      test_stream(k);
      test_stall(k);
      test_flush(k);
      test_wb(k);
      test_offset(k);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
